// File: rtl/dds_sweep_ctrl.sv
// Sweep sequencer for the DDS phase accumulator: captures a linear FTW sweep
// configuration, clears the accumulator, then steps the FTW with a per-step dwell.
module dds_sweep_ctrl #(
  parameter int FTW_W   = 32,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [FTW_W-1:0]   cfg_start_ftw,
  input  logic [FTW_W-1:0]   cfg_stop_ftw,
  input  logic [FTW_W-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_repeat,
  input  logic               go,
  input  logic               abort,
  output logic [FTW_W-1:0]   ftw,
  output logic               acc_clear,
  output logic               acc_enable,
  output logic               step_tick,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_CLEAR = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state;
  logic [FTW_W-1:0]   start_r;
  logic [FTW_W-1:0]   stop_r;
  logic [FTW_W-1:0]   step_r;
  logic [DWELL_W-1:0] dwell_r;
  logic               repeat_r;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               capture;
  logic               sweep_end;
  logic [FTW_W:0]     next_sum;

  assign cfg_ready  = (state == S_IDLE) || (state == S_ARMED);
  assign busy       = (state == S_CLEAR) || (state == S_RUN);
  assign acc_clear  = (state == S_CLEAR);
  assign acc_enable = (state == S_RUN);
  assign done       = (state == S_DONE);
  assign capture    = cfg_valid && cfg_ready;

  // One extra bit on the sum lets the clamp catch carry-out instead of wrapping.
  always_comb begin
    next_sum  = {1'b0, ftw} + {1'b0, step_r};
    sweep_end = (ftw == stop_r) || (start_r >= stop_r) || (step_r == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      start_r   <= '0;
      stop_r    <= '0;
      step_r    <= '0;
      dwell_r   <= '0;
      repeat_r  <= 1'b0;
      dwell_cnt <= '0;
      ftw       <= '0;
      step_tick <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      if (capture) begin
        start_r  <= cfg_start_ftw;
        stop_r   <= cfg_stop_ftw;
        step_r   <= cfg_step;
        dwell_r  <= cfg_dwell;
        repeat_r <= cfg_repeat;
      end
      case (state)
        S_IDLE: begin
          if (capture) state <= S_ARMED;
        end
        S_ARMED: begin
          // A same-cycle capture must feed the new start straight into CLEAR.
          if (go && !abort) begin
            state <= S_CLEAR;
            ftw   <= capture ? cfg_start_ftw : start_r;
          end
        end
        S_CLEAR: begin
          if (abort) begin
            state <= S_ARMED;
          end else begin
            state     <= S_RUN;
            dwell_cnt <= dwell_r;
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_ARMED;
          end else if (dwell_cnt != '0) begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end else begin
            dwell_cnt <= dwell_r;
            if (sweep_end) begin
              if (repeat_r) begin
                ftw       <= start_r;
                step_tick <= 1'b1;
              end else begin
                state <= S_DONE;
              end
            end else begin
              ftw       <= (next_sum > {1'b0, stop_r}) ? stop_r : next_sum[FTW_W-1:0];
              step_tick <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_ARMED;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed sweeps plus randomized
// configurations compared against a per-cycle FTW trace built from the sweep rules.
module tb_dds_sweep_ctrl;

  localparam int FTW_W   = 32;
  localparam int DWELL_W = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [FTW_W-1:0]   cfg_start_ftw;
  logic [FTW_W-1:0]   cfg_stop_ftw;
  logic [FTW_W-1:0]   cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_repeat;
  logic               go;
  logic               abort;
  logic [FTW_W-1:0]   ftw;
  logic               acc_clear;
  logic               acc_enable;
  logic               step_tick;
  logic               busy;
  logic               done;

  int errors = 0;
  int checks = 0;

  logic [FTW_W-1:0] exp_ftw[$];
  bit               exp_tick[$];

  dds_sweep_ctrl #(.FTW_W(FTW_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start_ftw(cfg_start_ftw), .cfg_stop_ftw(cfg_stop_ftw),
    .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_repeat(cfg_repeat),
    .go(go), .abort(abort),
    .ftw(ftw), .acc_clear(acc_clear), .acc_enable(acc_enable),
    .step_tick(step_tick), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected RUN-cycle trace: each FTW value held dwell+1 cycles; a tick marks
  // the first cycle of every value after the very first one.
  task automatic build_model(input logic [FTW_W-1:0] s, input logic [FTW_W-1:0] e,
                             input logic [FTW_W-1:0] st, input logic [DWELL_W-1:0] d,
                             input int passes);
    longint unsigned v;
    longint unsigned nv;
    bit first;
    bit fin;
    exp_ftw.delete();
    exp_tick.delete();
    first = 1'b1;
    for (int p = 0; p < passes; p++) begin
      v   = s;
      fin = 1'b0;
      while (!fin) begin
        for (int unsigned k = 0; k <= d; k++) begin
          exp_ftw.push_back(v[FTW_W-1:0]);
          exp_tick.push_back((k == 0) && !first);
          first = 1'b0;
        end
        if (v == e || s >= e || st == 0) begin
          fin = 1'b1;
        end else begin
          nv = v + st;
          v  = (nv > e) ? e : nv;
        end
      end
    end
  endtask

  task automatic configure(input logic [FTW_W-1:0] s, input logic [FTW_W-1:0] e,
                           input logic [FTW_W-1:0] st, input logic [DWELL_W-1:0] d,
                           input bit rep);
    bit taken;
    cfg_start_ftw = s;
    cfg_stop_ftw  = e;
    cfg_step      = st;
    cfg_dwell     = d;
    cfg_repeat    = rep;
    cfg_valid     = 1'b1;
    taken         = 1'b0;
    for (int i = 0; i < 20 && !taken; i++) begin
      if (cfg_ready) taken = 1'b1;
      tick();
    end
    cfg_valid = 1'b0;
    check("cfg_accept", taken, 1);
  endtask

  // Pulses go with whatever cfg inputs are present, then follows the sweep.
  // abort_at >= 0 aborts after that RUN cycle; vrun drives cfg_valid during the sweep.
  task automatic run_sweep(input logic [FTW_W-1:0] s, input logic [FTW_W-1:0] e,
                           input logic [FTW_W-1:0] st, input logic [DWELL_W-1:0] d,
                           input bit rep, input bit vrun, input int abort_at);
    int n;
    int ab;
    build_model(s, e, st, d, rep ? 3 : 1);
    ab = abort_at;
    if (ab >= exp_ftw.size()) ab = exp_ftw.size() - 1;
    go = 1'b1;
    tick();
    go = 1'b0;
    cfg_valid = vrun;
    check("clr_pulse", acc_clear, 1);
    check("clr_ftw", ftw, s);
    check("clr_en", acc_enable, 0);
    check("clr_busy", busy, 1);
    check("clr_ready", cfg_ready, 0);
    n = (ab >= 0) ? ab + 1 : exp_ftw.size();
    for (int i = 0; i < n; i++) begin
      tick();
      check("run_ftw", ftw, exp_ftw[i]);
      check("run_en", acc_enable, 1);
      check("run_clr", acc_clear, 0);
      check("run_tick", step_tick, exp_tick[i]);
      check("run_done", done, 0);
      check("run_ready", cfg_ready, 0);
    end
    if (ab >= 0) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_en", acc_enable, 0);
      check("abort_clr", acc_clear, 0);
      check("abort_done", done, 0);
      check("abort_busy", busy, 0);
      check("abort_ready", cfg_ready, 1);
      check("abort_ftw", ftw, exp_ftw[ab]);
      tick();
      check("abort_nodone", done, 0);
    end else begin
      tick();
      check("done_pulse", done, 1);
      check("done_ftw", ftw, exp_ftw[exp_ftw.size()-1]);
      check("done_en", acc_enable, 0);
      check("done_busy", busy, 0);
      tick();
      check("done_low", done, 0);
      check("armed_ready", cfg_ready, 1);
    end
  endtask

  initial begin
    logic [FTW_W-1:0] s, e, st;
    logic [DWELL_W-1:0] d;
    bit rep;

    reset = 1'b1; cfg_valid = 1'b0; go = 1'b0; abort = 1'b0;
    cfg_start_ftw = '0; cfg_stop_ftw = '0; cfg_step = '0; cfg_dwell = '0; cfg_repeat = 1'b0;

    // Reset: outputs idle, config offered during reset must not be taken.
    cfg_start_ftw = 32'd100; cfg_stop_ftw = 32'd130; cfg_step = 32'd10; cfg_dwell = 16'd2;
    cfg_valid = 1'b1;
    repeat (3) tick();
    check("rst_ftw", ftw, 0);
    check("rst_clr", acc_clear, 0);
    check("rst_en", acc_enable, 0);
    check("rst_tick", step_tick, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0; cfg_valid = 1'b0;
    tick();
    check("rst_ready", cfg_ready, 1);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("idle_go_clr", acc_clear, 0);
    check("idle_go_busy", busy, 0);

    // Basic sweep, run twice from the retained config.
    configure(32'd100, 32'd130, 32'd10, 16'd2, 1'b0);
    run_sweep(32'd100, 32'd130, 32'd10, 16'd2, 1'b0, 1'b0, -1);
    run_sweep(32'd100, 32'd130, 32'd10, 16'd2, 1'b0, 1'b0, -1);

    // Clamp to stop and carry-out clamp near the top of the range.
    configure(32'd0, 32'd25, 32'd10, 16'd0, 1'b0);
    run_sweep(32'd0, 32'd25, 32'd10, 16'd0, 1'b0, 1'b0, -1);
    configure(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, 1'b0);
    run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, 1'b0, 1'b0, -1);

    // Repeat wraps to start with a tick; abort partway through the 2nd pass.
    configure(32'd100, 32'd130, 32'd10, 16'd2, 1'b1);
    run_sweep(32'd100, 32'd130, 32'd10, 16'd2, 1'b1, 1'b0, 16);

    // cfg_valid held through a sweep is ignored, then captured together with go.
    configure(32'd100, 32'd130, 32'd10, 16'd2, 1'b0);
    cfg_start_ftw = 32'd7; cfg_stop_ftw = 32'd9; cfg_step = 32'd1; cfg_dwell = 16'd0; cfg_repeat = 1'b0;
    run_sweep(32'd100, 32'd130, 32'd10, 16'd2, 1'b0, 1'b1, -1);
    run_sweep(32'd7, 32'd9, 32'd1, 16'd0, 1'b0, 1'b0, -1);

    // abort together with go in ARMED: stays ARMED.
    abort = 1'b1; go = 1'b1;
    tick();
    abort = 1'b0; go = 1'b0;
    check("abort_go_clr", acc_clear, 0);
    check("abort_go_ready", cfg_ready, 1);

    // Reset in the middle of RUN while ftw=120.
    configure(32'd100, 32'd130, 32'd10, 16'd2, 1'b0);
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("mid_ftw120", ftw, 120);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_ftw", ftw, 0);
    check("mrst_en", acc_enable, 0);
    check("mrst_clr", acc_clear, 0);
    check("mrst_tick", step_tick, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_ready", cfg_ready, 1);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("mrst_go_clr", acc_clear, 0);

    // Randomized configurations, including ones near the top of the range.
    for (int i = 0; i < 24; i++) begin
      s  = $urandom_range(0, 200);
      e  = $urandom_range(0, 200);
      st = $urandom_range(0, 30);
      d  = $urandom_range(0, 3);
      rep = (i % 4 == 3);
      if ($urandom_range(0, 3) == 0) begin
        s  = s + 32'hFFFF_FF00;
        e  = e + 32'hFFFF_FF00;
        st = st + $urandom_range(0, 1) * 32'h8000_0000;
      end
      configure(s, e, st, d, rep);
      run_sweep(s, e, st, d, rep, 1'b0, rep ? int'($urandom_range(0, 40)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
